mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of requester and bus address ports.
REQ-002 Parameter: DW, 32, data width of all read/write data ports.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 inst_req  in  1  fetch stage requests an instruction read; held until inst_data_ok.
REQ-007 inst_addr  in  AW  fetch address; stable while inst_req is high.
REQ-008 data_req  in  1  memory stage requests a data access; held until data_data_ok.
REQ-009 data_wr  in  1  1 = write, 0 = read.
REQ-010 data_wen  in  4  byte write enables, used only when data_wr is 1.
REQ-011 data_addr, data_wdata  in  AW, DW  data access address and write data.
REQ-012 bus_req  out  1  shared memory port request.
REQ-013 bus_wr, bus_wen, bus_addr, bus_wdata  out  1, 4, AW, DW  shared-port command fields.
REQ-014 bus_addr_ok  in  1  memory accepted the command this cycle.
REQ-015 bus_data_ok  in  1  memory returns read data or write completion this cycle.
REQ-016 bus_rdata  in  DW  memory read data, valid with bus_data_ok.
REQ-017 inst_rdata, inst_data_ok  out  DW, 1  fetch response; inst_data_ok is a one-cycle pulse.
REQ-018 data_rdata, data_data_ok  out  DW, 1  data response; data_data_ok is a one-cycle pulse.
REQ-019 stallreq_for_bus  out  1  pipeline stall request to the stall controller.

Function
REQ-020 FSM states: IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT; at most one bus transaction outstanding.
REQ-021 IDLE: data_req high -> D_ADDR; else inst_req high -> I_ADDR; else stay. Data always wins a same-cycle conflict.
REQ-022 Grant owner, command fields and write data are registered on entry to x_ADDR and held constant until x_WAIT exits.
REQ-023 In I_ADDR/D_ADDR, bus_req = 1 and fields drive the latched command; bus_addr_ok high -> matching x_WAIT on the next edge.
REQ-024 In every state other than I_ADDR/D_ADDR, bus_req = 0; command fields hold their last value.
REQ-025 In I_WAIT/D_WAIT, bus_data_ok high -> matching x_data_ok = 1 for that cycle only (combinational from bus_data_ok), x_rdata = bus_rdata, next state IDLE.
REQ-026 bus_addr_ok and bus_data_ok in the same cycle while in x_ADDR: accept the address only; data_ok is ignored in that state.
REQ-027 inst_rdata/data_rdata hold the last returned word of their own requester; the other requester's response never changes them.
REQ-028 Minimum latency: request seen in IDLE at cycle N -> bus_req at N+1 -> with addr_ok at N+1 and data_ok at N+2, x_data_ok at N+2.
REQ-029 A requester dropping x_req mid-transaction does not abort it; the transaction completes and its data_ok pulse is still issued.
REQ-030 stallreq_for_bus = 1 when (data_req high and data_data_ok low) or (inst_req high and inst_data_ok low); otherwise 0.
REQ-031 Back-to-back operation: IDLE is visited for exactly one cycle between transactions; data priority is re-evaluated there, so a pending fetch waits while data_req stays high.
REQ-032 No combinational path from bus_addr_ok to bus_req.

Reset
REQ-033 rst high at a clock edge -> state IDLE, owner cleared, command fields 0, inst_rdata and data_rdata 0.
REQ-034 While rst is high, bus_req, inst_data_ok, data_data_ok and stallreq_for_bus are 0.
REQ-035 Reset mid-transaction abandons the transaction; any bus_data_ok in the first cycle after reset is ignored in IDLE.

Verification
REQ-036 Single fetch: inst_req, inst_addr = 0xBFC00000; addr_ok at cycle 1, data_ok at cycle 3 with rdata 0x24080001 -> inst_data_ok pulses at cycle 3, inst_rdata = 0x24080001, stallreq_for_bus high at cycles 0-2.
REQ-037 Conflict: inst_req and data_req (read, 0x80000010) rise together -> bus_addr = 0x80000010 first; after data_data_ok, one IDLE cycle, then bus_addr = inst_addr.
REQ-038 Write: data_wr = 1, data_wen = 0b0011, data_wdata = 0x12345678 -> bus_wr = 1, bus_wen = 0b0011, bus_wdata = 0x12345678 held until addr_ok; data_data_ok pulses on bus data_ok.
REQ-039 Slow slave: addr_ok withheld for 5 cycles -> bus_req and all command fields stay constant for all 5 cycles; stall stays high.
REQ-040 Reset in D_WAIT: rst for 1 cycle, then bus_data_ok asserted -> no data_data_ok pulse, state IDLE, bus_req = 0.
REQ-041 Simultaneous addr_ok and data_ok in D_ADDR -> transition to D_WAIT only; no data_data_ok until a later bus_data_ok.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// One transaction at a time; data wins conflicts.
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [3:0]    data_wen,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [3:0]    bus_wen,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          data_data_ok,
  output logic          stallreq_for_bus
);

  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    I_WAIT,
    D_ADDR,
    D_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic            wr_q, wr_d;
  logic [3:0]      wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   irdata_q, irdata_d;
  logic [DW-1:0]   drdata_q, drdata_d;

  logic            i_ok;
  logic            d_ok;

  // Responses only exist in a WAIT state, so a stray data_ok
  // in IDLE or an ADDR state is dropped.
  assign i_ok = !rst && (state_q == I_WAIT) && bus_data_ok;
  assign d_ok = !rst && (state_q == D_WAIT) && bus_data_ok;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d = D_ADDR;
          wr_d    = data_wr;
          wen_d   = data_wen;
          addr_d  = data_addr;
          wdata_d = data_wdata;
        end else if (inst_req) begin
          state_d = I_ADDR;
          wr_d    = 1'b0;
          wen_d   = 4'b0000;
          addr_d  = inst_addr;
          wdata_d = '0;
        end
      end
      I_ADDR: begin
        if (bus_addr_ok) state_d = I_WAIT;
      end
      I_WAIT: begin
        if (bus_data_ok) begin
          state_d  = IDLE;
          irdata_d = bus_rdata;
        end
      end
      D_ADDR: begin
        if (bus_addr_ok) state_d = D_WAIT;
      end
      D_WAIT: begin
        if (bus_data_ok) begin
          state_d  = IDLE;
          drdata_d = bus_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      wen_q    <= 4'b0000;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  // bus_req depends only on registered state, never on addr_ok.
  assign bus_req   = !rst &&
                     ((state_q == I_ADDR) || (state_q == D_ADDR));
  assign bus_wr    = wr_q;
  assign bus_wen   = wen_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  assign inst_data_ok = i_ok;
  assign data_data_ok = d_ok;
  assign inst_rdata   = i_ok ? bus_rdata : irdata_q;
  assign data_rdata   = d_ok ? bus_rdata : drdata_q;

  assign stallreq_for_bus = !rst &&
                            ((data_req && !d_ok) ||
                             (inst_req && !i_ok));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        stallreq_for_bus;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .data_req(data_req), .data_wr(data_wr),
    .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wen(bus_wen),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .stallreq_for_bus(stallreq_for_bus)
  );

  wire [136:0] outs = {bus_req, bus_wr, bus_wen, bus_addr,
                       bus_wdata, inst_data_ok, inst_rdata,
                       data_data_ok, data_rdata, stallreq_for_bus};

  task automatic chk(input string nm, input logic [136:0] act,
                     input logic [136:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic rst, ireq; logic [31:0] iaddr;
    logic dreq, dwr; logic [3:0] dwen;
    logic [31:0] daddr, dwdata;
    logic aok, dok; logic [31:0] rdata;
    logic [136:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic row(
    input logic r, input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [3:0] dn,
    input logic [31:0] da, input logic [31:0] dd,
    input logic ao, input logic dk, input logic [31:0] rd,
    input logic ebr, input logic ebw, input logic [3:0] ebn,
    input logic [31:0] eba, input logic [31:0] ebd,
    input logic eio, input logic [31:0] eir,
    input logic edo, input logic [31:0] edr, input logic est);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iaddr = ia;
    v.dreq = dr; v.dwr = dw; v.dwen = dn;
    v.daddr = da; v.dwdata = dd;
    v.aok = ao; v.dok = dk; v.rdata = rd;
    v.exp = {ebr, ebw, ebn, eba, ebd, eio, eir, edo, edr, est};
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    rst = 0; inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_wen = 0;
    data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: who owns the bus, whether the
  // address phase is done, and the latched command.
  int          m_owner;
  bit          m_acc;
  logic        m_wr;
  logic [3:0]  m_wen;
  logic [31:0] m_addr, m_wdata, m_ir, m_dr;
  logic        e_iok, e_dok;

  task automatic model_step(output logic [136:0] exp);
    logic busy, e_breq, e_st;
    logic [31:0] e_ir, e_dr;
    busy   = (m_owner != 0);
    e_breq = busy && !m_acc;
    e_iok  = busy && m_acc && (m_owner == 1) && bus_data_ok;
    e_dok  = busy && m_acc && (m_owner == 2) && bus_data_ok;
    e_ir   = e_iok ? bus_rdata : m_ir;
    e_dr   = e_dok ? bus_rdata : m_dr;
    e_st   = (data_req && !e_dok) || (inst_req && !e_iok);
    exp = {e_breq, m_wr, m_wen, m_addr, m_wdata,
           e_iok, e_ir, e_dok, e_dr, e_st};
    m_ir = e_ir;
    m_dr = e_dr;
    if (!busy) begin
      m_acc = 0;
      if (data_req) begin
        m_owner = 2; m_wr = data_wr; m_wen = data_wen;
        m_addr = data_addr; m_wdata = data_wdata;
      end else if (inst_req) begin
        m_owner = 1; m_wr = 0; m_wen = 0;
        m_addr = inst_addr; m_wdata = 0;
      end
    end else if (!m_acc) begin
      if (bus_addr_ok) m_acc = 1;
    end else if (bus_data_ok) begin
      m_owner = 0;
    end
  endtask

  localparam logic [31:0] A  = 32'hBFC00000;
  localparam logic [31:0] R  = 32'h24080001;
  localparam logic [31:0] D  = 32'h80000010;
  localparam logic [31:0] I  = 32'hBFC00100;
  localparam logic [31:0] W  = 32'h80000020;
  localparam logic [31:0] X  = 32'h12345678;
  localparam logic [31:0] R1 = 32'h11111111;
  localparam logic [31:0] R2 = 32'h22222222;
  localparam logic [31:0] RB = 32'hDEADBEEF;

  initial begin
    logic [136:0] exp;
    logic [31:0]  held_addr;
    idle_inputs();
    rst = 1;
    next_cycle();
    next_cycle();

    // reset, single fetch, conflict, write
    row(1,1,A,1,0,0,D,0,0,1,R,  0,0,0,0,0,0,0,0,0,0);
    row(0,1,A,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,0,0,0,1);
    row(0,1,A,0,0,0,0,0,1,0,0,  1,0,0,A,0,0,0,0,0,1);
    row(0,1,A,0,0,0,0,0,0,0,0,  0,0,0,A,0,0,0,0,0,1);
    row(0,1,A,0,0,0,0,0,0,1,R,  0,0,0,A,0,1,R,0,0,0);
    row(0,0,0,0,0,0,0,0,0,0,0,  0,0,0,A,0,0,R,0,0,0);
    row(0,1,I,1,0,0,D,0,0,0,0,  0,0,0,A,0,0,R,0,0,1);
    row(0,1,I,1,0,0,D,0,1,0,0,  1,0,0,D,0,0,R,0,0,1);
    row(0,1,I,1,0,0,D,0,0,1,R1, 0,0,0,D,0,0,R,1,R1,1);
    row(0,1,I,0,0,0,0,0,0,0,0,  0,0,0,D,0,0,R,0,R1,1);
    row(0,1,I,0,0,0,0,0,0,0,0,  1,0,0,I,0,0,R,0,R1,1);
    row(0,1,I,0,0,0,0,0,1,0,0,  1,0,0,I,0,0,R,0,R1,1);
    row(0,1,I,0,0,0,0,0,0,1,R2, 0,0,0,I,0,1,R2,0,R1,0);
    row(0,0,0,1,1,3,W,X,0,0,0,  0,0,0,I,0,0,R2,0,R1,1);
    row(0,0,0,1,1,3,W,X,0,0,0,  1,1,3,W,X,0,R2,0,R1,1);
    row(0,0,0,1,1,3,W,X,1,0,0,  1,1,3,W,X,0,R2,0,R1,1);
    row(0,0,0,1,1,3,W,X,0,1,RB, 0,1,3,W,X,0,R2,1,RB,0);
    row(0,0,0,0,0,0,0,0,0,0,0,  0,1,3,W,X,0,R2,0,RB,0);

    for (int k = 0; k < vq.size(); k++) begin
      rst = vq[k].rst; inst_req = vq[k].ireq;
      inst_addr = vq[k].iaddr; data_req = vq[k].dreq;
      data_wr = vq[k].dwr; data_wen = vq[k].dwen;
      data_addr = vq[k].daddr; data_wdata = vq[k].dwdata;
      bus_addr_ok = vq[k].aok; bus_data_ok = vq[k].dok;
      bus_rdata = vq[k].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d", k), outs, vq[k].exp);
      next_cycle();
    end

    // slow slave, then addr_ok and data_ok together in D_ADDR
    idle_inputs();
    data_req = 1; data_addr = 32'h80000040;
    data_wdata = 32'hAAAA5555;
    next_cycle();
    held_addr = 32'h80000040;
    for (int k = 0; k < 5; k++) begin
      data_wdata = $urandom;
      bus_data_ok = (k == 2);
      @(negedge clk);
      chk($sformatf("slow%0d", k),
          {bus_req, bus_wr, bus_wen, bus_addr, bus_wdata,
           stallreq_for_bus, data_data_ok},
          {1'b1, 1'b0, 4'b0, held_addr, 32'hAAAA5555, 1'b1, 1'b0});
      next_cycle();
    end
    bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    chk("both_ok_in_addr", {bus_req, data_data_ok}, {1'b1, 1'b0});
    next_cycle();
    bus_addr_ok = 0; bus_data_ok = 0;
    @(negedge clk);
    chk("wait_no_ok", {bus_req, data_data_ok, stallreq_for_bus},
        {1'b0, 1'b0, 1'b1});
    next_cycle();
    bus_data_ok = 1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("late_data_ok", {data_data_ok, data_rdata, stallreq_for_bus},
        {1'b1, 32'hCAFEF00D, 1'b0});
    next_cycle();
    idle_inputs();
    next_cycle();

    // reset while in D_WAIT
    data_req = 1; data_addr = 32'h80000050;
    next_cycle();
    bus_addr_ok = 1;
    next_cycle();
    bus_addr_ok = 0; rst = 1; bus_data_ok = 1;
    bus_rdata = 32'h55555555;
    @(negedge clk);
    chk("in_reset",
        {bus_req, data_data_ok, inst_data_ok, stallreq_for_bus},
        4'b0000);
    next_cycle();
    rst = 0; data_req = 0; bus_data_ok = 1;
    @(negedge clk);
    chk("after_reset",
        {bus_req, data_data_ok, data_rdata, bus_addr},
        {1'b0, 1'b0, 32'h0, 32'h0});
    next_cycle();
    bus_data_ok = 0;
    @(negedge clk);
    chk("idle_after_reset", {bus_req, stallreq_for_bus}, 2'b00);
    next_cycle();

    // randomized run against the model
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
    m_owner = 0; m_acc = 0; m_wr = 0; m_wen = 0;
    m_addr = 0; m_wdata = 0; m_ir = 0; m_dr = 0;
    e_iok = 0; e_dok = 0;
    for (int c = 0; c < 3000; c++) begin
      bus_addr_ok = ($urandom_range(0, 1) == 1);
      bus_data_ok = ($urandom_range(0, 2) == 0);
      bus_rdata = $urandom;
      if (inst_req && (e_iok || $urandom_range(0, 19) == 0))
        inst_req = 0;
      else if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req = 1; inst_addr = $urandom;
      end
      if (data_req && (e_dok || $urandom_range(0, 19) == 0))
        data_req = 0;
      else if (!data_req && $urandom_range(0, 3) == 0) begin
        data_req = 1; data_wr = $urandom_range(0, 1) == 1;
        data_wen = 4'($urandom); data_addr = $urandom;
        data_wdata = $urandom;
      end
      @(negedge clk);
      model_step(exp);
      if (outs !== exp)
        chk($sformatf("rand%0d", c), outs, exp);
      else
        checks++;
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
